// File: rtl/rx_frame_buffer.sv
// Receive frame buffer: stores depacketized bytes speculatively, commits whole frames and
// replays them as a first-word-fall-through stream. Optional CRC-8 check via RX_FRAME_CRC8_EN.
module rx_frame_buffer #(
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 255
) (
    input  logic              clk_32M768,
    input  logic              rst_n_32M768,
    input  logic [7:0]        in_tdata,
    input  logic              in_tvalid,
    input  logic              in_tlast,
    input  logic              in_tuser,
    output logic              in_tready,
    output logic [7:0]        out_tdata,
    output logic              out_tvalid,
    input  logic              out_tready,
    output logic              out_tlast,
    output logic [ADDR_W:0]   frames_pending,
    output logic              drop_pulse,
    output logic [7:0]        drop_count
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int LEN_W = $clog2(MAX_LEN + 2);
    localparam logic [PTR_W-1:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr, cm_ptr, rd_ptr;
    logic [LEN_W-1:0] frame_len;
    logic [8:0]       mem [2**ADDR_W];

    logic             acc, store, overflow, frame_ok, commit, drop_now;
    logic             rd_fire, rd_last;
    logic [PTR_W-1:0] wp, rd_next;
    logic [LEN_W-1:0] len_next;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

`ifdef RX_FRAME_CRC8_EN
    logic [7:0] crc, crc_next;

    function automatic logic [7:0] crc8_step(input logic [7:0] c_in, input logic [7:0] d);
        logic [7:0] c;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ d[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    always_comb begin
        acc      = in_tvalid && in_tready;
        // A start-of-frame byte always restarts from the last committed position.
        store    = acc && (in_tuser || state == RECV);
        wp       = in_tuser ? cm_ptr : wr_ptr;
        len_next = in_tuser ? LEN_W'(1) : frame_len + LEN_W'(1);
        overflow = ((wp - rd_ptr) == DEPTH) || (len_next > MAX_LEN_L);
`ifdef RX_FRAME_CRC8_EN
        crc_next = crc8_step(in_tuser ? 8'h00 : crc, in_tdata);
        frame_ok = (crc_next == 8'h00) && (len_next >= LEN_W'(2));
`else
        frame_ok = 1'b1;
`endif
        commit   = store && !overflow && in_tlast && frame_ok;
        drop_now = store && ((in_tuser && state == RECV) || overflow ||
                             (in_tlast && !frame_ok));
        rd_fire  = out_tvalid && out_tready;
        rd_last  = rd_fire && out_tlast;
        rd_next  = rd_fire ? rd_ptr + PTR_ONE : rd_ptr;
    end

    always_ff @(posedge clk_32M768) begin
        if (!rst_n_32M768) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            cm_ptr         <= '0;
            rd_ptr         <= '0;
            frame_len      <= '0;
            frames_pending <= '0;
            drop_count     <= '0;
            drop_pulse     <= 1'b0;
            out_tvalid     <= 1'b0;
            in_tready      <= 1'b0;
`ifdef RX_FRAME_CRC8_EN
            crc            <= '0;
`endif
        end else begin
            in_tready  <= 1'b1;
            drop_pulse <= drop_now;
            if (drop_now) drop_count <= sat_inc8(drop_count);
            rd_ptr     <= rd_next;
            // Compared against the pre-commit cm_ptr: first byte appears two cycles after tlast.
            out_tvalid <= (rd_next != cm_ptr);
            case ({commit, rd_last})
                2'b10:   frames_pending <= frames_pending + 1'b1;
                2'b01:   frames_pending <= frames_pending - 1'b1;
                default: ;
            endcase
            if (store) begin
                if (overflow) begin
                    wr_ptr <= cm_ptr;
                    state  <= in_tlast ? IDLE : DROP;
                end else if (in_tlast) begin
                    if (frame_ok) begin
                        cm_ptr <= wp + PTR_ONE;
                        wr_ptr <= wp + PTR_ONE;
                    end else begin
                        wr_ptr <= cm_ptr;
                    end
                    state <= IDLE;
                end else begin
                    wr_ptr    <= wp + PTR_ONE;
                    frame_len <= len_next;
                    state     <= RECV;
`ifdef RX_FRAME_CRC8_EN
                    crc       <= crc_next;
`endif
                end
            end else if (acc && state == DROP && in_tlast) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk_32M768) begin
        if (store && !overflow) mem[wp[ADDR_W-1:0]] <= {in_tlast, in_tdata};
        {out_tlast, out_tdata} <= mem[rd_next[ADDR_W-1:0]];
    end

endmodule

// File: tb/tb_rx_frame_buffer.sv
// Directed bench for rx_frame_buffer: a small-depth instance and a short-MAX_LEN instance
// share one input stream; vectors and expected outputs are hand-computed.
module tb_rx_frame_buffer;

    logic       clk_32M768 = 1'b0;
    logic       rst_n_32M768 = 1'b0;
    logic [7:0] in_tdata = 8'h00;
    logic       in_tvalid = 1'b0, in_tlast = 1'b0, in_tuser = 1'b0;
    logic       out_tready = 1'b0;

    logic       in_tready, out_tvalid, out_tlast, drop_pulse;
    logic [7:0] out_tdata, drop_count;
    logic [4:0] frames_pending;

    logic       ml_in_tready, ml_tvalid, ml_tlast, ml_drop_pulse;
    logic [7:0] ml_tdata, ml_drop_count;
    logic [8:0] ml_frames_pending;

    int checks = 0;
    int errors = 0;
    logic [8:0] got[$];
    logic [8:0] exp_q[$];

    always #5 clk_32M768 = ~clk_32M768;

    rx_frame_buffer #(.ADDR_W(4), .MAX_LEN(255)) dut (
        .clk_32M768(clk_32M768), .rst_n_32M768(rst_n_32M768),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tuser(in_tuser),
        .in_tready(in_tready),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tlast(out_tlast),
        .frames_pending(frames_pending), .drop_pulse(drop_pulse), .drop_count(drop_count));

    rx_frame_buffer #(.ADDR_W(8), .MAX_LEN(4)) dut_ml (
        .clk_32M768(clk_32M768), .rst_n_32M768(rst_n_32M768),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast), .in_tuser(in_tuser),
        .in_tready(ml_in_tready),
        .out_tdata(ml_tdata), .out_tvalid(ml_tvalid), .out_tready(out_tready), .out_tlast(ml_tlast),
        .frames_pending(ml_frames_pending), .drop_pulse(ml_drop_pulse), .drop_count(ml_drop_count));

    typedef struct {
        logic       v, u, l;
        logic [7:0] d;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic [4:0] efp;
        logic [7:0] edc;
        logic       edp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_32M768);
        rst_n_32M768 = 1'b0;
        in_tvalid = 1'b0;
        out_tready = 1'b0;
        repeat (2) @(posedge clk_32M768);
        @(negedge clk_32M768);
        rst_n_32M768 = 1'b1;
        @(posedge clk_32M768);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic u, input logic l);
        @(negedge clk_32M768);
        in_tdata = d; in_tuser = u; in_tlast = l; in_tvalid = 1'b1;
        @(posedge clk_32M768);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk_32M768);
        in_tvalid = 1'b0; in_tuser = 1'b0; in_tlast = 1'b0;
        repeat (n) @(posedge clk_32M768);
        #1;
    endtask

    // Records every byte that transfers (valid && ready at the following edge).
    task automatic collect(input bit use_ml, input int cycles);
        got.delete();
        @(negedge clk_32M768);
        in_tvalid = 1'b0; in_tuser = 1'b0; in_tlast = 1'b0;
        out_tready = 1'b1;
        repeat (cycles) begin
            if (use_ml ? ml_tvalid : out_tvalid)
                got.push_back(use_ml ? {ml_tlast, ml_tdata} : {out_tlast, out_tdata});
            @(negedge clk_32M768);
        end
    endtask

    task automatic cmp_stream(input string name);
        chk({name, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", name, i), got[i], exp_q[i]);
    endtask

    initial begin
        //          v  u  l  d      rdy ev ed     el efp  edc    edp
        vecs[0]  = '{1, 1, 0, 8'h01, 1, 0, 8'h00, 0, 0, 8'd0, 0};
        vecs[1]  = '{1, 0, 1, 8'h07, 1, 0, 8'h00, 0, 1, 8'd0, 0};
        vecs[2]  = '{0, 0, 0, 8'h00, 1, 1, 8'h01, 0, 1, 8'd0, 0};
        vecs[3]  = '{0, 0, 0, 8'h00, 1, 1, 8'h07, 1, 1, 8'd0, 0};
        vecs[4]  = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'd0, 0};
        vecs[5]  = '{1, 1, 0, 8'hAA, 1, 0, 8'h00, 0, 0, 8'd0, 0};
        vecs[6]  = '{1, 0, 0, 8'hBB, 1, 0, 8'h00, 0, 0, 8'd0, 0};
        vecs[7]  = '{1, 1, 0, 8'hCC, 1, 0, 8'h00, 0, 0, 8'd1, 1};
        vecs[8]  = '{1, 0, 1, 8'hDD, 1, 0, 8'h00, 0, 1, 8'd1, 0};
        vecs[9]  = '{0, 0, 0, 8'h00, 1, 1, 8'hCC, 0, 1, 8'd1, 0};
        vecs[10] = '{0, 0, 0, 8'h00, 1, 1, 8'hDD, 1, 1, 8'd1, 0};
        vecs[11] = '{0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 8'd1, 0};

        // Reset state while reset is held
        repeat (2) @(posedge clk_32M768);
        #1;
        chk("rst_in_tready", in_tready, 0);
        chk("rst_out_tvalid", out_tvalid, 0);
        chk("rst_frames_pending", frames_pending, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_drop_pulse", drop_pulse, 0);
        do_reset();
        chk("tready_after_rst", in_tready, 1);

        // Two-byte frame with latency, then rollback on a second tuser
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_32M768);
            in_tvalid = vecs[i].v; in_tuser = vecs[i].u; in_tlast = vecs[i].l;
            in_tdata = vecs[i].d; out_tready = vecs[i].rdy;
            @(posedge clk_32M768);
            #1;
            chk($sformatf("vec%0d_tvalid", i), out_tvalid, vecs[i].ev);
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_tdata", i), out_tdata, vecs[i].ed);
                chk($sformatf("vec%0d_tlast", i), out_tlast, vecs[i].el);
            end
            chk($sformatf("vec%0d_pending", i), frames_pending, vecs[i].efp);
            chk($sformatf("vec%0d_drop_count", i), drop_count, vecs[i].edc);
            chk($sformatf("vec%0d_drop_pulse", i), drop_pulse, vecs[i].edp);
        end

        // Buffer full: 16-entry buffer, reader stalled, two 10-byte frames
        do_reset();
        for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), i == 0, i == 9);
        for (int i = 0; i < 10; i++) send(8'h20 + 8'(i), i == 0, i == 9);
        idle(3);
        chk("full_pending", frames_pending, 1);
        chk("full_drop_count", drop_count, 1);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back({i == 9, 8'h10 + 8'(i)});
        collect(0, 20);
        cmp_stream("full_stream");
        chk("full_drained", out_tvalid, 0);
        chk("full_pending_end", frames_pending, 0);

        // Reset in the middle of an open frame
        do_reset();
        send(8'hA1, 1, 0); send(8'hA2, 0, 0); send(8'hA3, 0, 0);
        @(negedge clk_32M768);
        rst_n_32M768 = 1'b0; in_tvalid = 1'b0;
        @(posedge clk_32M768);
        #1;
        chk("midrst_tready", in_tready, 0);
        chk("midrst_pending", frames_pending, 0);
        @(negedge clk_32M768);
        rst_n_32M768 = 1'b1;
        @(posedge clk_32M768);
        send(8'h51, 1, 0); send(8'h52, 0, 1);
        idle(3);
        chk("midrst_pending_after", frames_pending, 1);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h51}); exp_q.push_back({1'b1, 8'h52});
        collect(0, 10);
        cmp_stream("midrst_stream");
        chk("midrst_drop_count", drop_count, 0);

        // Frame ending in 0x00 (CRC-dependent outcome)
        do_reset();
        send(8'h01, 1, 0); send(8'h00, 0, 1);
        exp_q.delete();
`ifdef RX_FRAME_CRC8_EN
        collect(0, 8);
        cmp_stream("crc_stream");
        chk("crc_drop_count", drop_count, 1);
`else
        exp_q.push_back({1'b0, 8'h01}); exp_q.push_back({1'b1, 8'h00});
        collect(0, 8);
        cmp_stream("crc_stream");
        chk("crc_drop_count", drop_count, 0);
`endif

        // Over-length frame on the MAX_LEN=4 instance, then a legal 3-byte frame
        do_reset();
        out_tready = 1'b1;
        for (int i = 0; i < 6; i++) send(8'h60 + 8'(i), i == 0, i == 5);
        send(8'h70, 1, 0); send(8'h71, 0, 0); send(8'h72, 0, 1);
        exp_q.delete();
        exp_q.push_back({1'b0, 8'h70}); exp_q.push_back({1'b0, 8'h71});
        exp_q.push_back({1'b1, 8'h72});
        collect(1, 12);
        cmp_stream("maxlen_stream");
        chk("maxlen_drop_count", ml_drop_count, 1);
        chk("maxlen_pending_end", ml_frames_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
